pu_msp430_wakeup_ctrl: RTL

- Low-power clock-enable sequencer and wakeup arbiter for the glitch-sensitive clock-gating path.
- Accepts a CPU sleep request and NSRC asynchronous wakeup sources. Produces a registered, glitch-free clock enable that feeds the clock-gating AND cell.
- Arbitrates simultaneous wakeups by fixed priority and reports the winning source.
- Runs on the free-running (ungated) clock, upstream of the gate.

---
 rtl/pu_msp430_wakeup_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/pu_msp430_wakeup_ctrl.sv
// rtl/pu_msp430_wakeup_ctrl.sv - clock-enable sequencer and fixed-priority wakeup arbiter
// Runs on the free-running clock; clk_en drives the downstream clock-gating cell.
module pu_msp430_wakeup_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WAKE_DLY    = 4
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    sleep_req,
  input  logic [NSRC-1:0]         src_req,
  input  logic [NSRC-1:0]         src_mask,
  output logic                    clk_en,
  output logic                    wkup,
  output logic [$clog2(NSRC)-1:0] wkup_id,
  output logic [1:0]              state
);

  localparam int IDW = $clog2(NSRC);
  localparam int CW  = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NSRC-1:0]   sync_q [SYNC_STAGES];
  logic [NSRC-1:0]   masked;
  logic              any_masked;
  logic [IDW-1:0]    win_id;
  logic              clk_en_q;
  logic              wkup_q;
  logic [IDW-1:0]    wkup_id_q;

  // Each source is an independent level, so a per-bit flop chain is enough.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= src_req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign masked     = sync_q[SYNC_STAGES-1] & src_mask;
  assign any_masked = |masked;

  // Scan downward so the lowest set index is the last assignment and wins.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) win_id = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (sleep_req && !any_masked) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (any_masked || !sleep_req) state_d = ST_RUN;
        else                          state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (any_masked) begin
          state_d = ST_WAKE;
          cnt_d   = CW'(WAKE_DLY - 1);
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are all registered from next-state so the gate enable never glitches.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      clk_en_q  <= 1'b1;
      wkup_q    <= 1'b0;
      wkup_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      wkup_q   <= (state_q == ST_WAKE) && (state_d == ST_RUN);
      if ((state_q == ST_SLEEP) && any_masked) wkup_id_q <= win_id;
    end
  end

  assign clk_en  = clk_en_q;
  assign wkup    = wkup_q;
  assign wkup_id = wkup_id_q;
  assign state   = state_q;

endmodule
